// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS datapath: immediate extension
// modes and the skid-buffer occupancy encoding.
package mips_pkg;

  localparam logic [1:0] MODE_SIGN   = 2'b00;
  localparam logic [1:0] MODE_ZERO   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } skid_state_t;

endpackage

// File: rtl/imm_extend_comb.sv
// Pure combinational immediate extender (sign / zero / LUI / branch offset),
// shared by the pipelined stage and the single-cycle core.
module imm_extend_comb
  import mips_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm_i,
  input  logic [1:0]       mode_i,
  output logic [OUT_W-1:0] ext_o
);

  localparam int PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] sext;

  always_comb begin
    sext  = {{PAD_W{imm_i[IN_W-1]}}, imm_i};
    ext_o = sext;
    case (mode_i)
      MODE_SIGN:   ext_o = sext;
      MODE_ZERO:   ext_o = {{PAD_W{1'b0}}, imm_i};
      MODE_UPPER:  ext_o = {imm_i, {PAD_W{1'b0}}};
      // Branch offset: word-aligned, the two top sign bits fall off.
      default:     ext_o = {sext[OUT_W-3:0], 2'b00};
    endcase
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage between decode and execute, with a
// two-entry skid buffer so the pipeline can stall without losing beats.
module imm_extend_stage
  import mips_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  if ((IN_W < 1) || (TAG_W < 1) || (OUT_W <= IN_W + 1)) begin : g_bad_params
    $error("imm_extend_stage: need IN_W >= 1, TAG_W >= 1 and OUT_W > IN_W + 1");
  end

  skid_state_t      state_q, state_d;
  logic             rdy_q, rdy_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic [OUT_W-1:0] ext_val;
  logic             in_fire, out_fire;

  imm_extend_comb #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_ext (
    .imm_i  (in_imm),
    .mode_i (in_mode),
    .ext_o  (ext_val)
  );

  // Ready comes from a register so it never depends on out_ready.
  assign in_ready  = rdy_q & ~reset;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    skid_data_d = skid_data_q;
    skid_tag_d  = skid_tag_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d    = ONE;
          out_data_d = ext_val;
          out_tag_d  = in_tag;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          out_data_d = ext_val;
          out_tag_d  = in_tag;
        end else if (in_fire) begin
          state_d     = FULL;
          skid_data_d = ext_val;
          skid_tag_d  = in_tag;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d    = ONE;
          out_data_d = skid_data_q;
          out_tag_d  = skid_tag_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    rdy_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      rdy_q       <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      skid_data_q <= skid_data_d;
      skid_tag_q  <= skid_tag_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Self-checking bench for imm_extend_stage: FIFO-level reference model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_imm_extend_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  logic        v8_in_valid, v8_in_ready;
  logic [7:0]  v8_in_imm;
  logic [1:0]  v8_in_mode;
  logic [4:0]  v8_in_tag;
  logic        v8_out_valid, v8_out_ready;
  logic [15:0] v8_out_data;
  logic [4:0]  v8_out_tag;

  int n_checks = 0;
  int n_fail   = 0;

  imm_extend_stage #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  imm_extend_stage #(.IN_W(8), .OUT_W(16), .TAG_W(5)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(v8_in_valid), .in_ready(v8_in_ready), .in_imm(v8_in_imm),
    .in_mode(v8_in_mode), .in_tag(v8_in_tag),
    .out_valid(v8_out_valid), .out_ready(v8_out_ready),
    .out_data(v8_out_data), .out_tag(v8_out_tag)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Arithmetic meaning of each mode, independent of bit slicing.
  function automatic logic [31:0] ext_m(input logic [15:0] imm, input logic [1:0] mode);
    longint u = longint'(imm);
    longint s = (u >= 32768) ? u - 65536 : u;
    longint r;
    case (mode)
      2'd0:    r = s;
      2'd1:    r = u;
      2'd2:    r = u * 65536;
      default: r = s * 4;
    endcase
    return 32'(r);
  endfunction

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
  } beat_t;

  beat_t q[$];
  bit    ready_m  = 1'b0;
  bit    post_rst = 1'b1;
  bit    started  = 1'b0;

  // Compare at mid-cycle against the model, then advance the model to the
  // state it must hold after the coming rising edge.
  always @(negedge clk) begin
    bit inf, outf;
    if (started) begin
      chk("model_out_valid", out_valid, q.size() != 0);
      chk("model_in_ready", in_ready, ready_m && !reset);
      if (q.size() != 0) begin
        chk("model_out_data", out_data, q[0].data);
        chk("model_out_tag", out_tag, q[0].tag);
      end else if (post_rst) begin
        chk("model_rst_data", out_data, 0);
        chk("model_rst_tag", out_tag, 0);
      end
    end
    if (reset) begin
      q.delete();
      ready_m  = 1'b0;
      post_rst = 1'b1;
      started  = 1'b1;
    end else if (started) begin
      inf  = in_valid && ready_m;
      outf = (q.size() != 0) && out_ready;
      if (outf) void'(q.pop_front());
      if (inf) begin
        beat_t b;
        b.data = ext_m(in_imm, in_mode);
        b.tag  = in_tag;
        q.push_back(b);
        post_rst = 1'b0;
      end
      ready_m = (q.size() < 2);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                       input logic [4:0] tag);
    in_valid = v;
    in_imm   = imm;
    in_mode  = mode;
    in_tag   = tag;
  endtask

  task automatic push1(input string name, input logic [15:0] imm, input logic [1:0] mode,
                       input logic [4:0] tag, input logic [31:0] exp);
    drive(1'b1, imm, mode, tag);
    cyc();
    in_valid = 1'b0;
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_data"}, out_data, exp);
    chk({name, "_tag"}, out_tag, tag);
  endtask

  task automatic push8(input string name, input logic [7:0] imm, input logic [1:0] mode,
                       input logic [4:0] tag, input logic [15:0] exp);
    v8_in_valid = 1'b1;
    v8_in_imm   = imm;
    v8_in_mode  = mode;
    v8_in_tag   = tag;
    chk({name, "_ready"}, v8_in_ready, 1);
    cyc();
    v8_in_valid = 1'b0;
    chk({name, "_valid"}, v8_out_valid, 1);
    chk({name, "_data"}, v8_out_data, exp);
    chk({name, "_tag"}, v8_out_tag, tag);
  endtask

  initial begin
    reset        = 1'b1;
    out_ready    = 1'b0;
    drive(1'b0, 16'h0, MODE_SIGN, 5'd0);
    v8_in_valid  = 1'b0;
    v8_in_imm    = 8'h0;
    v8_in_mode   = MODE_SIGN;
    v8_in_tag    = 5'd0;
    v8_out_ready = 1'b0;

    cyc(3);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    reset = 1'b0;
    chk("rst_release_ready_low", in_ready, 0);
    cyc();
    chk("rst_release_ready_high", in_ready, 1);

    out_ready = 1'b1;
    push1("sweep_sign",   16'h8001, MODE_SIGN,   5'd1, 32'hFFFF8001);
    push1("sweep_zero",   16'h8001, MODE_ZERO,   5'd2, 32'h00008001);
    push1("sweep_upper",  16'h8001, MODE_UPPER,  5'd3, 32'h80010000);
    push1("sweep_branch", 16'h8001, MODE_BRANCH, 5'd4, 32'hFFFE0004);
    push1("sweep_br_pos", 16'h7FFF, MODE_BRANCH, 5'd5, 32'h0001FFFC);
    cyc();
    chk("sweep_drained", out_valid, 0);

    out_ready = 1'b0;
    drive(1'b1, 16'h1111, MODE_SIGN, 5'd1);
    cyc();
    chk("bp_ready_one", in_ready, 1);
    drive(1'b1, 16'h2222, MODE_ZERO, 5'd2);
    cyc();
    chk("bp_ready_full", in_ready, 0);
    drive(1'b1, 16'h3333, MODE_UPPER, 5'd3);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_hold_ready", in_ready, 0);
      chk("bp_hold_tag", out_tag, 1);
      chk("bp_hold_data", out_data, 32'h00001111);
    end
    out_ready = 1'b1;
    cyc();
    chk("bp_second_tag", out_tag, 2);
    chk("bp_second_data", out_data, 32'h00002222);
    chk("bp_second_ready", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    chk("bp_third_tag", out_tag, 3);
    chk("bp_third_data", out_data, 32'h33330000);
    cyc();
    chk("bp_drained", out_valid, 0);

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'(i * 16'h1357), 2'(i), 5'(8 + i));
      cyc();
      chk("stream_ready", in_ready, 1);
      chk("stream_valid", out_valid, 1);
      chk("stream_tag", out_tag, 5'(8 + i));
    end
    in_valid = 1'b0;
    cyc();
    chk("stream_drained", out_valid, 0);

    out_ready = 1'b0;
    drive(1'b1, 16'h0F0F, MODE_SIGN, 5'd20);
    cyc();
    drive(1'b1, 16'hF0F0, MODE_SIGN, 5'd21);
    cyc();
    chk("mid_full_ready", in_ready, 0);
    in_valid = 1'b0;
    reset    = 1'b1;
    cyc();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_tag", out_tag, 0);
    chk("mid_rst_ready", in_ready, 0);
    reset = 1'b0;
    chk("mid_release_ready_low", in_ready, 0);
    cyc();
    chk("mid_release_ready_high", in_ready, 1);
    chk("mid_release_valid", out_valid, 0);
    out_ready = 1'b1;
    cyc(2);
    chk("mid_no_stale", out_valid, 0);

    out_ready = 1'b0;
    drive(1'b1, 16'h0101, MODE_SIGN, 5'd1);
    cyc();
    drive(1'b1, 16'h0202, MODE_SIGN, 5'd2);
    cyc();
    drive(1'b1, 16'hABCD, MODE_ZERO, 5'd30);
    cyc(2);
    chk("ill_ready", in_ready, 0);
    chk("ill_tag", out_tag, 1);
    chk("ill_data", out_data, 32'h00000101);
    out_ready = 1'b1;
    cyc();
    chk("ill_drain_tag", out_tag, 2);
    cyc();
    in_valid = 1'b0;
    chk("ill_late_tag", out_tag, 30);
    chk("ill_late_data", out_data, 32'h0000ABCD);
    cyc();
    chk("ill_drained", out_valid, 0);

    v8_out_ready = 1'b1;
    push8("w8_sign",   8'h80, MODE_SIGN,   5'd7,  16'hFF80);
    push8("w8_upper",  8'h80, MODE_UPPER,  5'd8,  16'h8000);
    push8("w8_branch", 8'h80, MODE_BRANCH, 5'd9,  16'hFE00);
    cyc();
    chk("w8_drained", v8_out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
